// File: rtl/depthwise_mram_pkg.sv
// Shared types and lane geometry for the depthwise MRAM writer.
// LANES pixels go into one MRAM word.
package depthwise_mram_pkg;

   localparam int LANES  = 4;
   localparam int LANE_W = $clog2(LANES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PACK = 2'd1,
      FIN  = 2'd2
   } state_e;

endpackage

// File: rtl/depthwise_mram_writer_if.sv
// Pixel stream in and MRAM Port A out of the depthwise writer.
// The writer uses the slave view; the source/memory side uses the master view.
interface depthwise_mram_writer_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int PIX_WIDTH  = 8
) ();
   logic                      pix_valid;
   logic [PIX_WIDTH-1:0]      pix_data;
   logic                      pix_ready;
   logic                      mram_en_a;
   logic [DATA_WIDTH/8-1:0]   mram_we_a;
   logic [ADDR_WIDTH-1:0]     mram_addr_a;
   logic [DATA_WIDTH-1:0]     mram_din_a;

   modport slave (
      input  pix_valid, pix_data,
      output pix_ready, mram_en_a, mram_we_a, mram_addr_a, mram_din_a
   );

   modport master (
      output pix_valid, pix_data,
      input  pix_ready, mram_en_a, mram_we_a, mram_addr_a, mram_din_a
   );
endinterface

// File: rtl/depthwise_byte_packer.sv
// Collects pixels into byte lanes of one word and flags when the word is complete.
// word_next/mask_next already include the pixel on the current handshake.
module depthwise_byte_packer
   import depthwise_mram_pkg::*;
#(
   parameter int PIX_WIDTH = 8
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        clear,
   input  logic                        accept,
   input  logic                        last,
   input  logic [PIX_WIDTH-1:0]        pix_data,
   output logic                        word_done,
   output logic [LANES*PIX_WIDTH-1:0]  word_next,
   output logic [LANES-1:0]            mask_next
);

   logic [LANE_W-1:0]          lane_idx;
   logic [LANES*PIX_WIDTH-1:0] pack_q;
   logic [LANES-1:0]           mask_q;

   always_comb begin
      word_next = pack_q;
      mask_next = mask_q;
      word_next[int'(lane_idx)*PIX_WIDTH +: PIX_WIDTH] = pix_data;
      mask_next[lane_idx] = 1'b1;
      word_done = accept && ((lane_idx == LANE_W'(LANES-1)) || last);
   end

   // A completed word leaves through the top's output registers, so the
   // packer restarts at lane 0 on the same edge and never stalls.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lane_idx <= '0;
         pack_q   <= '0;
         mask_q   <= '0;
      end else if (clear) begin
         lane_idx <= '0;
         pack_q   <= '0;
         mask_q   <= '0;
      end else if (accept) begin
         if (word_done) begin
            lane_idx <= '0;
            pack_q   <= '0;
            mask_q   <= '0;
         end else begin
            lane_idx <= lane_idx + LANE_W'(1);
            pack_q   <= word_next;
            mask_q   <= mask_next;
         end
      end
   end

endmodule

// File: rtl/depthwise_mram_writer.sv
// Packs a fixed-length 8-bit pixel stream into 32-bit words and writes them
// to MRAM Port A with byte enables, starting at a latched word address.
//
// state | meaning
// IDLE  | waiting for start
// PACK  | accepting pixels, emitting a word every 4th (or final) pixel
// FIN   | final write on the port; done follows
module depthwise_mram_writer
   import depthwise_mram_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int PIX_WIDTH  = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   start,
   input  logic [ADDR_WIDTH-1:0]  base_addr,
   input  logic [CNT_WIDTH-1:0]   num_pix,
   depthwise_mram_writer_if.slave bus,
   output logic                   busy,
   output logic                   done,
   output logic                   wrap_err
);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q;
   logic [CNT_WIDTH-1:0]  rem_q;
   logic                  start_acc;
   logic                  hs;
   logic                  last;
   logic                  word_done;
   logic [DATA_WIDTH-1:0] word_next;
   logic [LANES-1:0]      mask_next;

   assign start_acc     = (state_q == IDLE) && start;
   assign bus.pix_ready = (state_q == PACK);
   assign hs            = bus.pix_valid && (state_q == PACK);
   assign last          = (rem_q == CNT_WIDTH'(1));
   assign busy          = (state_q != IDLE);

   depthwise_byte_packer #(
      .PIX_WIDTH (PIX_WIDTH)
   ) u_packer (
      .clk       (clk),
      .resetn    (resetn),
      .clear     (start_acc),
      .accept    (hs),
      .last      (last),
      .pix_data  (bus.pix_data),
      .word_done (word_done),
      .word_next (word_next),
      .mask_next (mask_next)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (start) state_d = (num_pix == '0) ? FIN : PACK;
         PACK: if (hs && last) state_d = FIN;
         FIN:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ptr_q           <= '0;
         rem_q           <= '0;
         wrap_err        <= 1'b0;
         done            <= 1'b0;
         bus.mram_en_a   <= 1'b0;
         bus.mram_we_a   <= '0;
         bus.mram_addr_a <= '0;
         bus.mram_din_a  <= '0;
      end else begin
         bus.mram_en_a <= 1'b0;
         bus.mram_we_a <= '0;
         done          <= (state_q == FIN);
         if (start_acc) begin
            ptr_q    <= base_addr;
            rem_q    <= num_pix;
            wrap_err <= 1'b0;
         end else if (hs) begin
            rem_q <= rem_q - CNT_WIDTH'(1);
            if (word_done) begin
               bus.mram_en_a   <= 1'b1;
               bus.mram_we_a   <= mask_next;
               bus.mram_addr_a <= ptr_q;
               bus.mram_din_a  <= word_next;
               ptr_q           <= ptr_q + ADDR_WIDTH'(1);
               // Stepping off the top of the address space is flagged, not blocked.
               if (&ptr_q) wrap_err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_depthwise_mram_writer.sv
// Scoreboard bench for depthwise_mram_writer: expected writes are queued per job
// and compared as mram_en_a pulses appear.
module tb_depthwise_mram_writer;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic [9:0]  base_addr = '0;
   logic [15:0] num_pix = '0;
   logic        busy, done, wrap_err;

   depthwise_mram_writer_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .PIX_WIDTH(8)) bus ();

   depthwise_mram_writer #(
      .ADDR_WIDTH (10), .DATA_WIDTH (32), .PIX_WIDTH (8), .CNT_WIDTH (16)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start),
      .base_addr (base_addr),
      .num_pix   (num_pix),
      .bus       (bus),
      .busy      (busy),
      .done      (done),
      .wrap_err  (wrap_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [9:0]  addr;
      logic [31:0] data;
      logic [3:0]  we;
   } wr_t;

   wr_t sb[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  en_cnt = 0;
   int  last_hs_cyc = 0;
   int  done_cyc = 0;
   bit  done_seen = 0;
   logic done_busy = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.mram_en_a) begin
         en_cnt++;
         if (sb.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
         else begin
            wr_t e;
            e = sb.pop_front();
            chk("wr_addr", 32'(bus.mram_addr_a), 32'(e.addr));
            chk("wr_data", bus.mram_din_a, e.data);
            chk("wr_we", 32'(bus.mram_we_a), 32'(e.we));
         end
      end
      if (done) begin
         done_seen = 1;
         done_cyc  = cyc;
         done_busy = busy;
      end
   end

   task automatic push_job(input logic [9:0] base, input int n, input logic [7:0] first);
      for (int w = 0; w * 4 < n; w++) begin
         wr_t e;
         e.addr = base + 10'(w);
         e.data = '0;
         e.we   = '0;
         for (int k = 0; k < 4; k++) begin
            if (w * 4 + k < n) begin
               e.data[8*k +: 8] = first + 8'(w * 4 + k);
               e.we[k] = 1'b1;
            end
         end
         sb.push_back(e);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
   task automatic start_job(input logic [9:0] base, input int n, output int t);
      base_addr = base;
      num_pix   = 16'(n);
      start     = 1'b1;
      done_seen = 0;
      t = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic feed(input int n, input logic [7:0] first, input bit gaps);
      int  sent = 0;
      int  guard = 0;
      bit  hs_now;
      int  tcur;
      while (sent < n && guard < 1000) begin
         if (gaps && $urandom_range(0, 2) == 0) bus.pix_valid = 1'b0;
         else begin
            bus.pix_valid = 1'b1;
            bus.pix_data  = first + 8'(sent);
         end
         hs_now = bus.pix_valid && bus.pix_ready;
         tcur = cyc;
         @(posedge clk); #1;
         if (hs_now) begin
            sent++;
            last_hs_cyc = tcur;
         end
         guard++;
      end
      bus.pix_valid = 1'b0;
      if (sent < n) chk("feed_timeout", 32'(sent), 32'(n));
   endtask

   task automatic wait_done(input int exp_cyc);
      for (int i = 0; i < 20 && !done_seen; i++) begin
         @(negedge clk); #1;
      end
      @(posedge clk); #1;
      chk("done_seen", 32'(done_seen), 32'd1);
      chk("done_cycle", 32'(done_cyc), 32'(exp_cyc));
      chk("busy_at_done", 32'(done_busy), 32'd0);
   endtask

   initial begin
      int t;
      int en0;
      bus.pix_valid = 1'b0;
      bus.pix_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pix_ready", 32'(bus.pix_ready), 32'd0);
      chk("rst_en", 32'(bus.mram_en_a), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      resetn = 1'b1;
      @(posedge clk); #1;

      // 8 pixels, continuous valid
      push_job(10'h010, 8, 8'h01);
      en0 = en_cnt;
      start_job(10'h010, 8, t);
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_ready", 32'(bus.pix_ready), 32'd1);
      feed(8, 8'h01, 1'b0);
      wait_done(last_hs_cyc + 2);
      chk("t1_writes", 32'(en_cnt - en0), 32'd2);

      // 6 pixels: partial trailing word
      push_job(10'h020, 6, 8'h01);
      start_job(10'h020, 6, t);
      feed(6, 8'h01, 1'b0);
      wait_done(last_hs_cyc + 2);
      chk("t2_wrap", 32'(wrap_err), 32'd0);

      // first job again with random valid gaps
      push_job(10'h010, 8, 8'h01);
      en0 = en_cnt;
      start_job(10'h010, 8, t);
      feed(8, 8'h01, 1'b1);
      wait_done(last_hs_cyc + 2);
      chk("t3_writes", 32'(en_cnt - en0), 32'd2);

      // start while busy is ignored
      push_job(10'h100, 4, 8'h11);
      start_job(10'h100, 4, t);
      base_addr = 10'h200;
      num_pix   = 16'd8;
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      feed(4, 8'h11, 1'b0);
      wait_done(last_hs_cyc + 2);

      // wrap past top of address space
      push_job(10'h3FF, 8, 8'h31);
      start_job(10'h3FF, 8, t);
      feed(8, 8'h31, 1'b0);
      wait_done(last_hs_cyc + 2);
      chk("wrap_set", 32'(wrap_err), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      chk("wrap_sticky", 32'(wrap_err), 32'd1);

      // num_pix == 0: no write, done two cycles after start; also clears wrap_err
      en0 = en_cnt;
      start_job(10'h040, 0, t);
      chk("zero_wrap_clr", 32'(wrap_err), 32'd0);
      wait_done(t + 2);
      chk("zero_writes", 32'(en_cnt - en0), 32'd0);

      // reset after 3 handshakes
      en0 = en_cnt;
      start_job(10'h050, 8, t);
      feed(3, 8'h41, 1'b0);
      resetn = 1'b0;
      #2;
      chk("mid_rst_ready", 32'(bus.pix_ready), 32'd0);
      chk("mid_rst_en", 32'(bus.mram_en_a), 32'd0);
      chk("mid_rst_we", 32'(bus.mram_we_a), 32'd0);
      chk("mid_rst_addr", 32'(bus.mram_addr_a), 32'd0);
      chk("mid_rst_din", bus.mram_din_a, 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_wrap", 32'(wrap_err), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_nowrite", 32'(en_cnt - en0), 32'd0);

      push_job(10'h060, 4, 8'hA1);
      en0 = en_cnt;
      start_job(10'h060, 4, t);
      feed(4, 8'hA1, 1'b0);
      wait_done(last_hs_cyc + 2);
      chk("post_rst_writes", 32'(en_cnt - en0), 32'd1);

      repeat (3) @(posedge clk);
      #1;
      chk("sb_leftover", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1, "timeout");
   end

endmodule
